uart_xmtr: RTL and testbench

//   8N1 UART transmitter; FPGA-to-host counterpart of the UART receive path.

---
 rtl/uart_xmtr.sv | 149 ++++++++++++++
 tb/tb_uart_xmtr.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_xmtr.sv
// uart_xmtr: 8N1 UART transmitter with RTS/CTS flow control.
//   Bytes are taken from a valid/ready interface into a one-byte holding
//   register and sent on uart_tx least significant bit first. A frame is one
//   start bit, eight data bits and one stop bit. Every bit lasts exactly
//   CLKS_PER_BIT clocks, so a frame is 10*CLKS_PER_BIT clocks long.
//   Because of the holding register, a following frame can start with no
//   idle gap.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit period; must be >= 2
//
// Ports
//   clock     in   system clock; all logic runs on the rising edge
//   reset     in   synchronous, active-high reset
//   tx_data   in   [7:0] byte to send; taken when tx_valid && tx_ready
//   tx_valid  in   tx_data is valid
//   tx_ready  out  holding register is empty
//   uart_cts  in   asynchronous; high means the host can accept a frame
//   uart_tx   out  serial line; idles high; driven from a register
//   tx_busy   out  high while a frame is on the line
module uart_xmtr #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       uart_cts,
  output logic       uart_tx,
  output logic       tx_busy
);

  localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic [7:0]       hold_reg;
  logic             hold_full;
  logic             cts_meta;
  logic             cts_s;
  logic             start_ok;

  assign tx_ready = ~hold_full;
  // The CTS level is sampled only when a frame is about to start. Once a
  // frame has started, a CTS drop does not cut it short.
  assign start_ok = hold_full & cts_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      cts_meta  <= 1'b0;
      cts_s     <= 1'b0;
      uart_tx   <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      cts_meta <= uart_cts;
      cts_s    <= cts_meta;

      // A byte is accepted only into an empty holding register. The FSM
      // drains the register only when it is full. So the load below and the
      // clear in the FSM never happen on the same edge.
      if (tx_valid && !hold_full) begin
        hold_reg  <= tx_data;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (start_ok) begin
            shift_reg <= hold_reg;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            state     <= START;
            uart_tx   <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end

        START: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
            uart_tx <= shift_reg[0];
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt   <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              // Drive the next bit now. It is the bit that the shift on this
              // edge moves into position 0.
              uart_tx <= shift_reg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (start_ok) begin
              // Back-to-back case: the next start bit follows the stop bit
              // with no idle gap.
              shift_reg <= hold_reg;
              hold_full <= 1'b0;
              state     <= START;
              uart_tx   <= 1'b0;
            end else begin
              state   <= IDLE;
              uart_tx <= 1'b1;
              tx_busy <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xmtr.sv
// tb_uart_xmtr: self-checking bench for uart_xmtr.
//   A fast instance (CLKS_PER_BIT=4) runs the directed cases and a
//   randomized stream. A second instance (CLKS_PER_BIT=217) sends one frame.
//   Each expected frame is built from the byte value as {stop, data, start}.
//   The bench checks every line sample against it, counts the busy cycles
//   and decodes the byte at mid-bit, as a receiver would.
module tb_uart_xmtr;

  localparam int CPB   = 4;
  localparam int CPB_L = 217;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       uart_cts;
  logic       uart_tx;
  logic       tx_busy;

  logic [7:0] l_data;
  logic       l_valid;
  logic       l_ready;
  logic       l_cts;
  logic       l_tx;
  logic       l_busy;

  logic sel_long = 1'b0;
  logic line;
  logic busy;
  assign line = sel_long ? l_tx   : uart_tx;
  assign busy = sel_long ? l_busy : tx_busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  exp_q[$];
  logic        rand_done;

  always #5 clock = ~clock;

  uart_xmtr #(.CLKS_PER_BIT(CPB)) dut (
    .clock    (clock),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .uart_cts (uart_cts),
    .uart_tx  (uart_tx),
    .tx_busy  (tx_busy)
  );

  uart_xmtr #(.CLKS_PER_BIT(CPB_L)) dut_long (
    .clock    (clock),
    .reset    (reset),
    .tx_data  (l_data),
    .tx_valid (l_valid),
    .tx_ready (l_ready),
    .uart_cts (l_cts),
    .uart_tx  (l_tx),
    .tx_busy  (l_busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Presents a byte on the fast instance and waits until it is accepted.
  // Returns at the falling edge that follows the accepting rising edge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clock);
    while (!tx_ready && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 1000) check("send_timeout", n, 0);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // Call at a falling edge. Waits at most max_wait cycles for the start bit.
  // Then checks the whole 10*cpb-cycle frame and returns one cycle after it.
  task automatic expect_frame(input logic [7:0] b, input int cpb, input int max_wait,
                              output int waited);
    logic [9:0] bits;
    logic [7:0] dec;
    int         good;
    int         busy_n;
    bits   = {1'b1, b, 1'b0};
    dec    = '0;
    busy_n = 0;
    waited = 0;
    while (line !== 1'b0 && waited < max_wait) begin
      @(negedge clock);
      waited++;
    end
    check("start_seen", int'(line), 0);
    for (int i = 0; i < 10; i++) begin
      good = 0;
      for (int j = 0; j < cpb; j++) begin
        if (line === bits[i]) good++;
        if (busy === 1'b1) busy_n++;
        if (j == cpb / 2 && i >= 1 && i <= 8) dec[i-1] = line;
        @(negedge clock);
      end
      check($sformatf("bit%0d_cycles_cpb%0d", i, cpb), good, cpb);
    end
    check("busy_cycles", busy_n, 10 * cpb);
    check("decoded_byte", int'(dec), int'(b));
  endtask

  initial begin
    int         w;
    int         cnt_a;
    int         cnt_b;
    logic [7:0] b;

    reset    = 1'b1;
    tx_data  = '0;
    tx_valid = 1'b0;
    uart_cts = 1'b1;
    l_data   = '0;
    l_valid  = 1'b0;
    l_cts    = 1'b1;
    rand_done = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_uart_tx",  int'(uart_tx),  1);
    check("rst_tx_ready", int'(tx_ready), 1);
    check("rst_tx_busy",  int'(tx_busy),  0);
    check("rst_long_tx",  int'(l_tx),     1);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // Case 1: a single byte 0xA5. The start bit should follow acceptance
    // after one cycle.
    send(8'hA5);
    expect_frame(8'hA5, CPB, 20, w);
    check("a5_latency", w, 1);
    cnt_a = 0;
    for (int i = 0; i < 8; i++) begin
      if (uart_tx === 1'b1 && tx_busy === 1'b0 && tx_ready === 1'b1) cnt_a++;
      @(negedge clock);
    end
    check("a5_idle_after", cnt_a, 8);

    // Case 2: two frames back to back. The second start bit must follow the
    // stop bit directly.
    fork
      begin
        send(8'h00);
        send(8'hFF);
        check("b2b_ready_low_when_held", int'(tx_ready), 0);
      end
      begin
        expect_frame(8'h00, CPB, 20, w);
        expect_frame(8'hFF, CPB, 0, w);
        check("b2b_no_gap", w, 0);
      end
    join
    check("b2b_ready_after", int'(tx_ready), 1);

    // Case 3: CTS held low blocks the frame. Raising CTS starts it after
    // two synchroniser cycles plus one.
    uart_cts = 1'b0;
    repeat (4) @(negedge clock);
    send(8'h3C);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 100; i++) begin
      if (uart_tx === 1'b1) cnt_a++;
      if (tx_ready === 1'b0) cnt_b++;
      @(negedge clock);
    end
    check("cts_low_line_idle", cnt_a, 100);
    check("cts_low_ready_low", cnt_b, 100);
    uart_cts = 1'b1;
    expect_frame(8'h3C, CPB, 20, w);
    check("cts_rise_latency", w, 3);

    // Case 4: CTS drops during data bit 3. The frame in progress completes.
    // The held byte waits for CTS.
    b = 8'($urandom);
    fork
      begin
        send(8'h81);
        send(b);
        repeat (15) @(negedge clock);
        uart_cts = 1'b0;
      end
      expect_frame(8'h81, CPB, 20, w);
    join
    cnt_a = 0;
    for (int i = 0; i < 30; i++) begin
      if (uart_tx === 1'b1 && tx_ready === 1'b0) cnt_a++;
      @(negedge clock);
    end
    check("cts_drop_held", cnt_a, 30);
    uart_cts = 1'b1;
    expect_frame(b, CPB, 20, w);
    check("cts_return_latency", w, 3);

    // Case 5: a reset during data bit 5 aborts the frame at once.
    send(8'($urandom));
    repeat (26) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_uart_tx",  int'(uart_tx),  1);
    check("midrst_tx_busy",  int'(tx_busy),  0);
    check("midrst_tx_ready", int'(tx_ready), 1);
    reset = 1'b0;
    send(8'h55);
    expect_frame(8'h55, CPB, 20, w);

    // Randomized stream: random bytes, random gaps between them, and CTS
    // toggling at random.
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          logic [7:0] r;
          r = 8'($urandom);
          send(r);
          exp_q.push_back(r);
          repeat ($urandom_range(0, 6)) @(negedge clock);
        end
      end
      begin
        for (int k = 0; k < 24; k++) begin
          int n;
          int ww;
          n = 0;
          while (exp_q.size() == 0 && n < 2000) begin
            @(negedge clock);
            n++;
          end
          if (exp_q.size() == 0) begin
            check("rand_queue_timeout", n, 0);
            break;
          end
          expect_frame(exp_q.pop_front(), CPB, 400, ww);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          uart_cts = ($urandom_range(0, 3) != 0);
          repeat ($urandom_range(1, 30)) @(negedge clock);
        end
        uart_cts = 1'b1;
      end
    join
    check("rand_queue_empty", exp_q.size(), 0);

    // Case 6: a full-rate frame on the 217-clock instance.
    sel_long = 1'b1;
    check("long_ready", int'(l_ready), 1);
    l_data  = 8'h0D;
    l_valid = 1'b1;
    @(negedge clock);
    l_valid = 1'b0;
    expect_frame(8'h0D, CPB_L, 20, w);
    check("long_latency", w, 1);
    check("long_idle_after", int'(l_tx), 1);
    sel_long = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
